// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit scanning, per-slot
// anode blanking, frame-synchronous display updates and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic                SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic                AN_INV  = (AN_ACT_LOW != 0);
  localparam logic [6:0]          SEG_OFF = {7{SEG_INV}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_INV}};

  logic [CW-1:0]              pre;
  logic [IW-1:0]              idx;
  logic [N_DIGITS-1:0][3:0]   disp_val, pend_val;
  logic [N_DIGITS-1:0]        disp_dp, pend_dp;
  logic                       pend_f;
  logic                       pre_last, idx_last, bnd, active, blank;
  logic [3:0]                 nib;
  logic [N_DIGITS-1:0]        upz, onehot;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h3F; 4'h1: enc = 7'h06; 4'h2: enc = 7'h5B; 4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66; 4'h5: enc = 7'h6D; 4'h6: enc = 7'h7D; 4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F; 4'h9: enc = 7'h6F; 4'hA: enc = 7'h77; 4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39; 4'hD: enc = 7'h5E; 4'hE: enc = 7'h79; default: enc = 7'h71;
    endcase
  endfunction

  assign pre_last = (pre == CW'(SCAN_DIV - 1));
  assign idx_last = (idx == IW'(N_DIGITS - 1));
  assign bnd      = enable & pre_last & idx_last;

  // upz[i]: digit i and every digit above it are zero
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_upz
    assign upz[i] = ~|disp_val[N_DIGITS-1:i];
  end

  assign nib    = disp_val[idx];
  assign active = enable && (32'(pre) >= BLANK_CYC);
  assign blank  = lzb && (idx != '0) && upz[idx];
  assign onehot = N_DIGITS'(1) << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      idx      <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_f   <= 1'b0;
    end else begin
      if (enable) begin
        if (pre_last) begin
          pre <= '0;
          idx <= idx_last ? '0 : idx + 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
      // A load landing on the boundary bypasses pending straight to display
      if (load && bnd) begin
        disp_val <= value;
        disp_dp  <= dp_in;
        pend_f   <= 1'b0;
      end else if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_f   <= 1'b1;
      end else if (bnd && pend_f) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pend_f   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= SEG_INV;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= active ? ((blank ? 7'h00 : enc(nib)) ^ SEG_OFF) : SEG_OFF;
      dp         <= active ? (disp_dp[idx] ^ SEG_INV) : SEG_INV;
      an         <= active ? (onehot ^ AN_OFF) : AN_OFF;
      frame_done <= bnd;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a cycle-count based display model.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic          lzb = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int n_chk = 0;
  int n_fail = 0;

  // model state: t counts enabled cycles since reset
  int          t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_dpp;
  bit          m_pf;
  logic [6:0]  enc_tbl [16];

  seg7_scan_ctrl #(
    .N_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACT_LOW(0), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lzb(lzb), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_dpd = '0; m_dpp = '0; m_pf = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h00);
    chk({tag, "_dp"},  32'(dp), 32'h0);
    chk({tag, "_an"},  32'(an), 32'hF);
    chk({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  // one clock: predict outputs from pre-edge state/inputs, check, advance model
  task automatic step();
    int phase, slot, nv;
    logic [6:0] e_seg; logic e_dp; logic [3:0] e_an; logic e_fd;
    phase = t % SD;
    slot  = (t / SD) % ND;
    e_seg = 7'h00; e_dp = 1'b0; e_an = 4'hF; e_fd = 1'b0;
    if (rst_n && enable && phase >= BC) begin
      nv    = int'((m_disp >> (4 * slot)) & 16'hF);
      e_seg = (lzb && slot != 0 && (m_disp >> (4 * slot)) == 0) ? 7'h00 : enc_tbl[nv];
      e_dp  = m_dpd[slot];
      e_an  = ~(4'b0001 << slot);
    end
    e_fd = rst_n && enable && phase == SD - 1 && slot == ND - 1;
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp",  32'(dp),  32'(e_dp));
    chk("an",  32'(an),  32'(e_an));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (!rst_n) begin
      model_reset();
    end else begin
      if (load && e_fd) begin
        m_disp = value; m_dpd = dp_in; m_pf = 0;
      end else if (load) begin
        m_pend = value; m_dpp = dp_in; m_pf = 1;
      end else if (e_fd && m_pf) begin
        m_disp = m_pend; m_dpd = m_dpp; m_pf = 0;
      end
      if (enable) t++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    enc_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    #12;
    chk_idle("reset");
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    #4;

    // basic hex decode, dp and anode pattern
    enable = 1'b1;
    do_load(16'h12AF, 4'b0101);
    run(40);
    // leading-zero blanking on and off
    lzb = 1'b1;
    do_load(16'h0005, 4'b1000);
    run(36);
    lzb = 1'b0;
    run(20);
    // mid-frame update waits for the boundary
    do_load(16'h2222, 4'b0000);
    run(22);
    do_load(16'h1111, 4'b0000);
    run(30);
    // back-to-back loads within one frame: last wins
    do_load(16'h3333, 4'b0000);
    run(2);
    do_load(16'h4444, 4'b0000);
    run(34);
    // scan pause mid-slot
    run(2);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(20);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(3))
        0: v &= 16'h000F;
        1: v &= 16'h00FF;
        2: v &= 16'h0FFF;
        default: ;
      endcase
      enable = ($urandom_range(9) != 0);
      load   = ($urandom_range(9) == 0);
      value  = v;
      dp_in  = 4'($urandom);
      lzb    = 1'($urandom);
      step();
    end
    load = 1'b0; enable = 1'b1;

    // async reset mid-frame with a pending value
    run(5);
    do_load(16'hBEEF, 4'b1111);
    run(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    model_reset();
    run(3);
    rst_n = 1'b1;
    lzb = 1'b0;
    run(40);

    for (int i = 0; i < 500; i++) begin
      enable = ($urandom_range(7) != 0);
      load   = ($urandom_range(7) == 0);
      value  = 16'($urandom);
      dp_in  = 4'($urandom);
      lzb    = 1'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
